mmu_config_sequencer: RTL

MMU_CONFIG_SEQUENCER -- requirements
Module: mmu_config_sequencer

---
 rtl/mmu_config_pkg.sv | 20 ++
 rtl/mmu_outstanding_counter.sv | 46 ++++
 rtl/mmu_config_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mmu_config_pkg.sv
// Shared definitions for the MMU config sequencer: register word indices,
// sequencer states and STATUS bit positions.
package mmu_config_pkg;

  // Word index taken from cfg address bits [3:2]
  localparam logic [1:0] REG_IDX_SRAM_SEQSEC = 2'd0;
  localparam logic [1:0] REG_IDX_SCM_SEQSEC  = 2'd1;
  localparam logic [1:0] REG_IDX_STATUS      = 2'd2;
  localparam logic [1:0] REG_IDX_RSVD        = 2'd3;

  localparam int unsigned STATUS_BUSY_BIT    = 0;
  localparam int unsigned STATUS_PENDING_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } seq_state_e;

endpackage

// File: rtl/mmu_outstanding_counter.sv
// Tracks in-flight TCDM transactions: adds granted requests, subtracts
// returned responses each cycle, saturating at 0 and at the port capacity.
module mmu_outstanding_counter #(
  parameter int NB_PORTS        = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(NB_PORTS*MAX_OUTSTANDING+1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NB_PORTS-1:0] req_gnt_i,
  input  logic [NB_PORTS-1:0] r_valid_i,
  output logic [CNT_W-1:0]    cnt_o
);

  localparam int MAX_CNT = NB_PORTS * MAX_OUTSTANDING;

  int n_gnt;
  int n_rsp;
  int cnt_sum;

  always_comb begin
    n_gnt = 0;
    n_rsp = 0;
    for (int unsigned i = 0; i < NB_PORTS; i++) begin
      n_gnt += int'(req_gnt_i[i]);
      n_rsp += int'(r_valid_i[i]);
    end
    cnt_sum = int'(cnt_o) + n_gnt - n_rsp;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (cnt_sum < 0) begin
      cnt_o <= '0;
    end else if (cnt_sum > MAX_CNT) begin
      cnt_o <= CNT_W'(MAX_CNT);
    end else begin
      cnt_o <= CNT_W'(cnt_sum);
    end
  end

  a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_sum >= 0);
  a_cnt_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_sum <= MAX_CNT);

endmodule

// File: rtl/mmu_config_sequencer.sv
// Config-bus front end for the MMU sequential-section sizes: a new size is
// held in a shadow register and applied only once TCDM traffic has drained.
module mmu_config_sequencer
  import mmu_config_pkg::*;
#(
  parameter int NB_PORTS        = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_WIDTH        = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_req_i,
  input  logic [31:0]         cfg_add_i,
  input  logic                cfg_wen_i,
  input  logic [31:0]         cfg_wdata_i,
  input  logic [3:0]          cfg_be_i,
  input  logic [ID_WIDTH-1:0] cfg_id_i,
  output logic                cfg_gnt_o,
  output logic                cfg_r_valid_o,
  output logic [31:0]         cfg_r_rdata_o,
  output logic                cfg_r_opc_o,
  output logic [ID_WIDTH-1:0] cfg_r_id_o,
  input  logic [NB_PORTS-1:0] tcdm_req_gnt_i,
  input  logic [NB_PORTS-1:0] tcdm_r_valid_i,
  output logic                tcdm_block_o,
  output logic [3:0]          mmu_sram_seqsec_size_o,
  output logic [3:0]          mmu_scm_seqsec_size_o
);

  localparam int CNT_W = $clog2(NB_PORTS*MAX_OUTSTANDING+1);

  seq_state_e       state;
  logic [3:0]       shadow_sram;
  logic [3:0]       shadow_scm;
  logic [3:0]       applied_sram;
  logic [3:0]       applied_scm;
  logic [CNT_W-1:0] out_cnt;
  logic [1:0]       reg_idx;
  logic             busy;
  logic             pending;
  logic             wr_accept;
  logic             load_sram;
  logic             load_scm;
  logic [31:0]      resp_rdata;
  logic             resp_opc;
  logic             unused_cfg;

  mmu_outstanding_counter #(
    .NB_PORTS        (NB_PORTS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) i_outstanding_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_gnt_i (tcdm_req_gnt_i),
    .r_valid_i (tcdm_r_valid_i),
    .cnt_o     (out_cnt)
  );

  assign unused_cfg = ^{cfg_add_i[31:4], cfg_add_i[1:0], cfg_wdata_i[31:4], cfg_be_i[3:1]};

  assign reg_idx = cfg_add_i[3:2];
  assign busy    = (state != IDLE);
  assign pending = (shadow_sram != applied_sram) || (shadow_scm != applied_scm);

  // Reads are always served; writes only when no update is in progress
  assign cfg_gnt_o = rst_ni & cfg_req_i & (cfg_wen_i | (state == IDLE));
  assign wr_accept = cfg_gnt_o & ~cfg_wen_i;
  assign load_sram = wr_accept && cfg_be_i[0] && (reg_idx == REG_IDX_SRAM_SEQSEC)
                     && (cfg_wdata_i[3:0] != applied_sram);
  assign load_scm  = wr_accept && cfg_be_i[0] && (reg_idx == REG_IDX_SCM_SEQSEC)
                     && (cfg_wdata_i[3:0] != applied_scm);

  assign mmu_sram_seqsec_size_o = applied_sram;
  assign mmu_scm_seqsec_size_o  = applied_scm;

  always_comb begin
    resp_rdata = '0;
    resp_opc   = 1'b0;
    case (reg_idx)
      REG_IDX_SRAM_SEQSEC: if (cfg_wen_i) resp_rdata = {28'd0, applied_sram};
      REG_IDX_SCM_SEQSEC:  if (cfg_wen_i) resp_rdata = {28'd0, applied_scm};
      REG_IDX_STATUS: begin
        if (cfg_wen_i) begin
          resp_rdata[STATUS_BUSY_BIT]    = busy;
          resp_rdata[STATUS_PENDING_BIT] = pending;
        end else begin
          resp_opc = 1'b1;
        end
      end
      default: resp_opc = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      shadow_sram   <= '0;
      shadow_scm    <= '0;
      applied_sram  <= '0;
      applied_scm   <= '0;
      tcdm_block_o  <= 1'b0;
      cfg_r_valid_o <= 1'b0;
      cfg_r_rdata_o <= '0;
      cfg_r_opc_o   <= 1'b0;
      cfg_r_id_o    <= '0;
    end else begin
      cfg_r_valid_o <= cfg_gnt_o;
      cfg_r_rdata_o <= cfg_gnt_o ? resp_rdata : '0;
      cfg_r_opc_o   <= cfg_gnt_o & resp_opc;
      if (cfg_gnt_o) cfg_r_id_o <= cfg_id_i;

      // tcdm_block_o is set alongside the state so it decodes DRAIN/APPLY
      case (state)
        IDLE: begin
          if (load_sram || load_scm) begin
            state        <= DRAIN;
            tcdm_block_o <= 1'b1;
            if (load_sram) shadow_sram <= cfg_wdata_i[3:0];
            if (load_scm)  shadow_scm  <= cfg_wdata_i[3:0];
          end
        end
        DRAIN: begin
          if ((out_cnt == '0) && (tcdm_req_gnt_i == '0)) state <= APPLY;
        end
        APPLY: begin
          applied_sram <= shadow_sram;
          applied_scm  <= shadow_scm;
          state        <= IDLE;
          tcdm_block_o <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          tcdm_block_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
